// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: control, ROM-side and stream-side signals of the burst reader
interface rom_burst_reader_if #(
    parameter int blockLength = 8,
    parameter int memDepth    = 4096
);
    localparam int addressBitWidth = $clog2(memDepth);
    logic                       start;
    logic [addressBitWidth-1:0] startAddress;
    logic [addressBitWidth:0]   burstLength;
    logic                       busy;
    logic                       done;
    logic [addressBitWidth-1:0] romAddress;
    logic [blockLength-1:0]     romData;
    logic [blockLength-1:0]     dataOut;
    logic                       dataValid;
    logic                       dataReady;
    modport slave (
        input  start, startAddress, burstLength, romData, dataReady,
        output busy, done, romAddress, dataOut, dataValid
    );
    modport master (
        output start, startAddress, burstLength, romData, dataReady,
        input  busy, done, romAddress, dataOut, dataValid
    );
endinterface

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: issues a burst of ROM reads and streams the words out with full backpressure
module rom_burst_reader #(
    parameter int blockLength = 8,
    parameter int memDepth    = 4096
) (
    input logic               clock,
    input logic               reset,
    rom_burst_reader_if.slave bus
);
    localparam int addressBitWidth = $clog2(memDepth);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                     state_q, state_d;
    logic [addressBitWidth-1:0] addr_q, addr_d, addr_next;
    logic [addressBitWidth:0]   rem_q, rem_d;
    logic                       rd_q, rd_d, dv_q, dv_d;
    logic                       busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [blockLength-1:0]     buf_q [3];
    logic [blockLength-1:0]     buf_d [3];
    logic [1:0]                 cnt_q, cnt_d, cnt_p;
    logic [2:0]                 occ;
    logic                       pop, can_issue;
    // The registered head buf_q[0] feeds dataOut; two entries behind it absorb
    // the address and ROM-data stages when the consumer stalls, so a word is
    // only issued when a slot is guaranteed for it.
    assign pop       = valid_q & bus.dataReady;
    assign occ       = {1'b0, cnt_q} + {2'b0, rd_q} + {2'b0, dv_q};
    assign can_issue = occ < 3'd3 + {2'b0, pop};
    assign addr_next = (addr_q == addressBitWidth'(memDepth - 1)) ? '0 : addr_q + 1'b1;
    assign dv_d      = rd_q;
    // Output buffer: pop shifts the head out, the arriving ROM word lands behind what remains
    always_comb begin
        buf_d = buf_q;
        cnt_p = cnt_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            cnt_p    = cnt_q - 2'd1;
        end
        for (int i = 0; i < 3; i++)
            if (dv_q && cnt_p == 2'(i)) buf_d[i] = bus.romData;
        cnt_d   = cnt_p + {1'b0, dv_q};
        valid_d = cnt_d != 2'd0;
    end
    // Burst sequencing: the first read is issued straight from IDLE, done fires after the final handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rd_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.burstLength == '0) begin
                    done_d = 1'b1;
                end else begin
                    addr_d  = bus.startAddress;
                    rd_d    = 1'b1;
                    rem_d   = bus.burstLength - 1'b1;
                    busy_d  = 1'b1;
                    state_d = (bus.burstLength == 1) ? DRAIN : RUN;
                end
            end
            RUN: if (can_issue) begin
                addr_d  = addr_next;
                rd_d    = 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == 1) ? DRAIN : RUN;
            end
            DRAIN: if (!rd_q && !dv_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rd_q    <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rd_q    <= rd_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.romAddress = addr_q;
    assign bus.dataOut    = buf_q[0];
    assign bus.dataValid  = valid_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed and randomized bursts checked against a queue-based reference model
module tb_rom_burst_reader;
    localparam int DEPTH = 4096;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rom_burst_reader_if #(.blockLength(8), .memDepth(DEPTH)) bus();
    rom_burst_reader #(.blockLength(8), .memDepth(DEPTH)) dut (.clock(clk), .reset(rst_n), .bus(bus));
    logic [7:0] rom [DEPTH];
    // Behavioural synchronous-read ROM
    always @(posedge clk) bus.romData <= rom[bus.romAddress];
    int checks = 0, errors = 0, cyc = 0;
    int q[$];
    bit mbusy = 0, await_first = 0;
    int acc_cyc = -100, done_cyc = -100, delivered = 0, ready_mode = 0, phase = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pick();
        phase++;
        return ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ((phase - 1) % 4 == 0 || (phase - 1) % 4 == 3) : ($urandom_range(0, 3) != 0);
    endfunction

    task automatic tick();
        bit hs, stall, acc, dn, was_rst, old_busy;
        logic [7:0] held;
        int a0;
        hs = bus.dataValid === 1'b1 && bus.dataReady === 1'b1;
        stall = bus.dataValid === 1'b1 && bus.dataReady !== 1'b1;
        held = bus.dataOut;
        acc = 0;
        dn = 0;
        was_rst = !rst_n;
        old_busy = mbusy;
        a0 = int'(bus.startAddress);
        if (was_rst) begin
            q.delete();
            mbusy = 0;
            await_first = 0;
        end else begin
            if (hs) begin
                chk("extra_beat", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("beat_data", bus.dataOut, rom[q[0]]);
                    void'(q.pop_front());
                    delivered++;
                    if (q.size() == 0 && old_busy) begin
                        mbusy = 0;
                        dn = 1;
                    end
                end
            end
            if (!old_busy && bus.start === 1'b1) begin
                if (bus.burstLength == 0) dn = 1;
                else begin
                    for (int k = 0; k < int'(bus.burstLength); k++) q.push_back((a0 + k) % DEPTH);
                    mbusy = 1;
                    acc = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", bus.busy, mbusy);
        chk("done", bus.done, dn);
        if (was_rst) begin
            chk("rst_valid", bus.dataValid, 0);
            chk("rst_addr", bus.romAddress, 0);
            chk("rst_data", bus.dataOut, 0);
        end else if (stall) begin
            chk("stall_valid", bus.dataValid, 1);
            chk("stall_data", bus.dataOut, held);
        end
        if (acc) begin
            chk("first_addr", bus.romAddress, a0);
            acc_cyc = cyc;
            await_first = 1;
            delivered = 0;
        end
        if (dn) done_cyc = cyc;
        if (await_first && cyc == acc_cyc + 2) begin
            chk("latency", bus.dataValid, 1);
            await_first = 0;
        end
        if (q.size() == 0) chk("idle_valid", bus.dataValid, 0);
        else chk("lookahead", ((int'(bus.romAddress) - q[0] + DEPTH) % DEPTH) <= 2, 1);
    endtask

    task automatic launch(input int addr, input int len);
        bus.startAddress = 12'(addr);
        bus.burstLength = 13'(len);
        bus.start = 1'b1;
        bus.dataReady = pick();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run(input int limit, input int poke_at);
        int n = 0;
        while (mbusy && n < limit) begin
            bus.dataReady = pick();
            bus.start = (n == poke_at);
            if (n == poke_at) begin
                bus.startAddress = 12'($urandom_range(0, DEPTH - 1));
                bus.burstLength = 13'($urandom_range(1, 9));
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        chk("timeout", n < limit, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, d1;
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
        bus.start = 1'b0;
        bus.startAddress = '0;
        bus.burstLength = '0;
        bus.dataReady = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ready_mode = 0;
        launch(10, 4);
        run(50, -1);
        chk("basic_done_at", done_cyc - acc_cyc, 6);
        chk("basic_count", delivered, 4);
        ready_mode = 1;
        phase = 0;
        launch(0, 6);
        run(100, -1);
        chk("bp_count", delivered, 6);
        ready_mode = 0;
        launch(4094, 4);
        run(50, -1);
        chk("wrap_count", delivered, 4);
        launch(77, 0);
        tick();
        chk("zero_done_at", done_cyc, cyc - 1);
        ready_mode = 2;
        launch(100, 5);
        run(100, 2);
        chk("ignore_start_count", delivered, 5);
        ready_mode = 0;
        launch(200, 8);
        n = 0;
        while (delivered < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_reset_count", delivered, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        launch(20, 3);
        run(50, -1);
        chk("post_reset_count", delivered, 3);
        bus.startAddress = 12'd300;
        bus.burstLength = 13'd3;
        bus.start = 1'b1;
        tick();
        n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_first_done", bus.done, 1);
        d1 = cyc;
        tick();
        chk("b2b_accept_at", acc_cyc, d1 + 1);
        bus.start = 1'b0;
        run(50, -1);
        chk("b2b_count", delivered, 3);
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 40);
            launch($urandom_range(0, DEPTH - 1), n);
            run(400, $urandom_range(0, 5));
            chk("rand_count", delivered, n);
        end
        launch($urandom_range(0, DEPTH - 1), DEPTH);
        run(12000, -1);
        chk("full_count", delivered, DEPTH);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
